fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_ctrl_pc_gen.sv | 29 ++
 rtl/fetch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared defines for the fetch controller: stall vector layout,
// reset fetch address and FSM state encodings.
package fetch_ctrl_pkg;

  localparam int unsigned STALL_W   = 6;
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE_V = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID_V   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX_V   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM_V  = 6'b011111;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc_gen.sv
// pc_gen: 32-bit program counter with word-aligned load and +4 step.
// Ports: clk, rst, hold, load, load_addr, pc.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_addr,
  output logic [31:0] pc
);

  logic [31:0] r_pc;

  // Load beats step; the step wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= load_addr & 32'hFFFF_FFFC;
    end else if (!hold) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage controller. Issues instruction requests, buffers
// stalled returns, handles branch redirects and drives stall/flush.
// Ports: stallreq_*_i, branch_*_i, inst_* memory side, stall_o,
// flush_o, if_pc_o/if_inst_o/if_valid_o toward IF/ID.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               stallreq_mem_i,
  input  logic               branch_flag_i,
  input  logic [31:0]        branch_target_i,
  output logic               inst_req_o,
  output logic [31:0]        inst_addr_o,
  input  logic               inst_ack_i,
  input  logic [31:0]        inst_data_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_inst_o,
  output logic               if_valid_o
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] w_pc;
  logic [31:0] r_buf;
  logic [31:0] r_tgt;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_valid;

  logic        w_stall_if;
  logic        w_br_acc;
  logic        w_pc_hold;
  logic        w_pc_load;
  logic [31:0] w_pc_addr;
  logic        w_cap;
  logic        w_pres;
  logic        w_bub;
  logic        w_buf_wr;
  logic        w_tgt_wr;

  always_comb begin
    stall_o = STALL_NONE_V;
    if (rst) begin
      stall_o = STALL_NONE_V;
    end else if (stallreq_mem_i) begin
      stall_o = STALL_MEM_V;
    end else if (stallreq_ex_i) begin
      stall_o = STALL_EX_V;
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID_V;
    end
  end

  assign w_stall_if = stall_o[STALL_IF];
  // A branch resolved in a stalled EX is not yet real.
  assign w_br_acc = branch_flag_i && !stall_o[STALL_EX] && !rst;
  assign flush_o = w_br_acc;

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .hold      (w_pc_hold),
    .load      (w_pc_load),
    .load_addr (w_pc_addr),
    .pc        (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_hold   = 1'b1;
    w_pc_load   = 1'b0;
    w_pc_addr   = branch_target_i;
    w_cap       = 1'b0;
    w_pres      = 1'b0;
    w_bub       = 1'b0;
    w_buf_wr    = 1'b0;
    w_tgt_wr    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        w_bub       = 1'b1;
        w_pc_load   = w_br_acc;
      end
      ST_FETCH: begin
        if (w_br_acc) begin
          w_bub = 1'b1;
          if (inst_ack_i) begin
            w_pc_load = 1'b1;
          end else begin
            // Bus must see the old request through; park the target.
            w_tgt_wr    = 1'b1;
            w_state_nxt = ST_DISCARD;
          end
        end else if (inst_ack_i && !w_stall_if) begin
          w_cap     = 1'b1;
          w_pc_hold = 1'b0;
        end else if (inst_ack_i) begin
          w_buf_wr    = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (!w_stall_if) begin
          w_bub = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_br_acc) begin
          w_bub       = 1'b1;
          w_pc_load   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (!w_stall_if) begin
          w_pres      = 1'b1;
          w_pc_hold   = 1'b0;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        w_bub = 1'b1;
        if (w_br_acc) begin
          if (inst_ack_i) begin
            w_pc_load   = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_tgt_wr = 1'b1;
          end
        end else if (inst_ack_i) begin
          w_pc_load   = 1'b1;
          w_pc_addr   = r_tgt;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_pc    <= 32'd0;
      r_if_inst  <= 32'd0;
      r_if_valid <= 1'b0;
      r_buf      <= 32'd0;
      r_tgt      <= 32'd0;
    end else begin
      if (w_cap) begin
        r_if_pc    <= w_pc;
        r_if_inst  <= inst_data_i;
        r_if_valid <= 1'b1;
      end else if (w_pres) begin
        r_if_pc    <= w_pc;
        r_if_inst  <= r_buf;
        r_if_valid <= 1'b1;
      end else if (w_bub) begin
        r_if_valid <= 1'b0;
      end
      if (w_buf_wr) begin
        r_buf <= inst_data_i;
      end else if (w_br_acc) begin
        r_buf <= 32'd0;
      end
      if (w_tgt_wr) begin
        r_tgt <= branch_target_i;
      end
    end
  end

  assign inst_req_o  = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
  assign inst_addr_o = w_pc;
  assign if_pc_o     = r_if_pc;
  assign if_inst_o   = r_if_inst;
  assign if_valid_o  = r_if_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed per-cycle vector test for fetch_ctrl plus hand-written
// sequences for stall priority, wrap and mid-request reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sid, sex, smem;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] ifpc, ifinst;
  logic        ifvalid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: word content is a fixed tag of its address.
  assign data = 32'hC0DE_0000 ^ addr;

  fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id_i   (sid),
    .stallreq_ex_i   (sex),
    .stallreq_mem_i  (smem),
    .branch_flag_i   (br),
    .branch_target_i (tgt),
    .inst_req_o      (req),
    .inst_addr_o     (addr),
    .inst_ack_i      (ack),
    .inst_data_i     (data),
    .stall_o         (stall),
    .flush_o         (flush),
    .if_pc_o         (ifpc),
    .if_inst_o       (ifinst),
    .if_valid_o      (ifvalid)
  );

  typedef struct {
    logic        rst, sid, sex, smem, br;
    logic [31:0] tgt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic [5:0]  stall;
    logic        flush, valid;
    logic [31:0] ifpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic i, input logic e, input logic m,
    input logic b, input logic [31:0] t, input logic a,
    input logic q, input logic [31:0] ad, input logic [5:0] s,
    input logic f, input logic v, input logic [31:0] p);
    vec_t x;
    x.rst = r; x.sid = i; x.sex = e; x.smem = m; x.br = b;
    x.tgt = t; x.ack = a; x.req = q; x.addr = ad; x.stall = s;
    x.flush = f; x.valid = v; x.ifpc = p;
    return x;
  endfunction

  task automatic chk(input string nm, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic e,
                       input logic m, input logic b,
                       input logic [31:0] t, input logic a);
    rst = r; sid = i; sex = e; smem = m; br = b; tgt = t; ack = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    //          rst i e m br tgt        ack  req addr          stall   fl v ifpc
    tbl.push_back(mk(1,0,0,1,1,32'h40, 1,   0,32'h0,   6'h00, 0,0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   0,32'h0,   6'h00, 0,0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h0,   6'h00, 0,0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h4,   6'h00, 0,1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h8,   6'h00, 0,1,32'h4));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'hC,   6'h00, 0,1,32'h8));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   1,32'h10,  6'h00, 0,1,32'hC));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   1,32'h10,  6'h00, 0,0,32'hC));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   1,32'h10,  6'h00, 0,0,32'hC));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h10,  6'h00, 0,0,32'hC));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h14,  6'h00, 0,1,32'h10));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h18,  6'h00, 0,1,32'h14));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h1C,  6'h00, 0,1,32'h18));
    tbl.push_back(mk(0,0,1,0,0,32'h0,  1,   1,32'h20,  6'h0F, 0,1,32'h1C));
    tbl.push_back(mk(0,0,1,0,0,32'h0,  0,   0,32'h20,  6'h0F, 0,1,32'h1C));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   0,32'h20,  6'h00, 0,1,32'h1C));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   1,32'h24,  6'h00, 0,1,32'h20));
    tbl.push_back(mk(0,0,0,0,1,32'h103,0,   1,32'h24,  6'h00, 1,0,32'h20));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   1,32'h24,  6'h00, 0,0,32'h20));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h24,  6'h00, 0,0,32'h20));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   1,32'h100, 6'h00, 0,0,32'h20));
    tbl.push_back(mk(0,0,0,1,1,32'h200,0,   1,32'h100, 6'h1F, 0,0,32'h20));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  1,   1,32'h100, 6'h00, 0,0,32'h20));
    tbl.push_back(mk(0,0,0,0,1,32'h300,1,   1,32'h104, 6'h00, 1,1,32'h100));
    tbl.push_back(mk(0,0,0,0,0,32'h0,  0,   1,32'h300, 6'h00, 0,0,32'h100));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].sid, tbl[k].sex, tbl[k].smem,
            tbl[k].br, tbl[k].tgt, tbl[k].ack);
      @(negedge clk);
      chk("req",   k, {31'd0, req},     {31'd0, tbl[k].req});
      chk("addr",  k, addr,             tbl[k].addr);
      chk("stall", k, {26'd0, stall},   {26'd0, tbl[k].stall});
      chk("flush", k, {31'd0, flush},   {31'd0, tbl[k].flush});
      chk("valid", k, {31'd0, ifvalid}, {31'd0, tbl[k].valid});
      chk("ifpc",  k, ifpc,             tbl[k].ifpc);
      if (tbl[k].valid)
        chk("ifinst", k, ifinst, 32'hC0DE_0000 ^ tbl[k].ifpc);
      next_cycle();
    end

    // ID stall alone, then EX+ID together (EX wins).
    drive(0, 1, 0, 0, 0, 32'd0, 1);
    @(negedge clk);
    chk("h_stall_id", 100, {26'd0, stall}, 32'h07);
    chk("h_addr300", 100, addr, 32'h300);
    next_cycle();
    drive(0, 1, 1, 0, 0, 32'd0, 0);
    @(negedge clk);
    chk("h_stall_prio", 101, {26'd0, stall}, 32'h0F);
    chk("h_hold_req", 101, {31'd0, req}, 32'd0);
    next_cycle();
    // Branch out of HOLD to the top word of the address space.
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    @(negedge clk);
    chk("h_flush_hold", 102, {31'd0, flush}, 32'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'd0, 1);
    @(negedge clk);
    chk("h_addr_top", 103, addr, 32'hFFFF_FFFC);
    chk("h_bubble", 103, {31'd0, ifvalid}, 32'd0);
    chk("h_flush_pulse", 103, {31'd0, flush}, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'd0, 1);
    @(negedge clk);
    chk("h_addr_wrap", 104, addr, 32'h0);
    chk("h_ifpc_top", 104, ifpc, 32'hFFFF_FFFC);
    chk("h_ifinst_top", 104, ifinst, 32'hC0DE_0000 ^ 32'hFFFF_FFFC);
    next_cycle();
    // Reset while request for 0x4 is outstanding.
    drive(1, 0, 0, 0, 0, 32'd0, 0);
    @(negedge clk);
    chk("h_req_pre_rst", 105, {31'd0, req}, 32'd1);
    chk("h_addr4", 105, addr, 32'h4);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'd0, 1);
    @(negedge clk);
    chk("h_req_idle", 106, {31'd0, req}, 32'd0);
    chk("h_addr_rst", 106, addr, 32'h0);
    chk("h_valid_rst", 106, {31'd0, ifvalid}, 32'd0);
    chk("h_ifinst_rst", 106, ifinst, 32'd0);
    chk("h_ifpc_rst", 106, ifpc, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'd0, 1);
    @(negedge clk);
    chk("h_restart_req", 107, {31'd0, req}, 32'd1);
    chk("h_restart_valid", 107, {31'd0, ifvalid}, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'd0, 0);
    @(negedge clk);
    chk("h_restart_addr", 108, addr, 32'h4);
    chk("h_restart_ifpc", 108, ifpc, 32'h0);
    chk("h_restart_v", 108, {31'd0, ifvalid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
